// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//   Turns a noisy, possibly asynchronous level (switch, button, external line)
//   into a glitch-free level that feeds signal_in of the downstream
//   edge_detector. A candidate level is accepted only after STABLE_CNT
//   consecutive equal samples. Any disagreeing sample during qualification
//   aborts it and raises a one-cycle glitch pulse.
//
// Parameters
//   STABLE_CNT   consecutive equal samples needed to accept a level (1..2**CNT_W-1)
//   CNT_W        qualification counter width
//   RESET_LEVEL  level loaded into signal_out, the synchronizer and the FSM on reset
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-low reset
//   signal_raw  in   noisy input level
//   signal_out  out  debounced level (registered)
//   busy        out  1 while a candidate level is being qualified (registered)
//   glitch      out  one-cycle pulse when a qualification aborts (registered)
//
// Configuration macro
//   DEBOUNCER_SYNC_EN  defined: signal_raw passes through a 2-flop synchronizer
//                      (two extra cycles of latency).
//                      undefined: signal_raw is sampled directly, for sources
//                      that are already synchronous to clk.
// -----------------------------------------------------------------------------
module input_debouncer #(
    parameter int   STABLE_CNT  = 4,
    parameter int   CNT_W       = 8,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic signal_raw,
    output logic signal_out,
    output logic busy,
    output logic glitch
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(STABLE_CNT - 1);
    localparam state_t           RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

    // Sample seen by the FSM.
    logic sample;

`ifdef DEBOUNCER_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk) begin
        // NOTE: the synchronizer is reset to RESET_LEVEL so the FSM does not
        // see a phantom transition from a stale value right after reset.
        if (!reset) begin
            sync1_q <= RESET_LEVEL;
            sync2_q <= RESET_LEVEL;
        end else begin
            sync1_q <= signal_raw;
            sync2_q <= sync1_q;
        end
    end

    assign sample = sync2_q;
`else
    assign sample = signal_raw;
`endif

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             out_q;
    logic             busy_q;
    logic             glitch_q;

    // In a CHK state the candidate is the level being qualified; CHK_HI is
    // only ever entered from a low output, CHK_LO from a high one.
    logic candidate;
    assign candidate = (state_q == CHK_HI);

    always_ff @(posedge clk) begin
        // NOTE: every state register uses non-blocking assignment so all of
        // them update together from the values held before this edge.
        if (!reset) begin
            state_q  <= RESET_STATE;
            cnt_q    <= '0;
            out_q    <= RESET_LEVEL;
            busy_q   <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            glitch_q <= 1'b0;
            case (state_q)
                STABLE_LO, STABLE_HI: begin
                    cnt_q <= '0;
                    if (sample != out_q) begin
                        if (STABLE_CNT == 1) begin
                            // A single sample suffices: accept immediately.
                            out_q   <= sample;
                            state_q <= sample ? STABLE_HI : STABLE_LO;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= sample ? CHK_HI : CHK_LO;
                            cnt_q   <= CNT_W'(1);
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end

                CHK_HI, CHK_LO: begin
                    if (sample == candidate) begin
                        if (cnt_q == LAST_CNT) begin
                            out_q   <= candidate;
                            state_q <= candidate ? STABLE_HI : STABLE_LO;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q  <= cnt_q + CNT_W'(1);
                            busy_q <= 1'b1;
                        end
                    end else begin
                        // Bounce: drop the candidate, keep the old level.
                        state_q  <= out_q ? STABLE_HI : STABLE_LO;
                        cnt_q    <= '0;
                        busy_q   <= 1'b0;
                        glitch_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= RESET_STATE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign signal_out = out_q;
    assign busy       = busy_q;
    assign glitch     = glitch_q;

endmodule
